// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, colour constants and the colour-bar lookup
// shared by the VGA scan driver and its sync delay line.
package vga_timing_pkg;

   localparam int COORD_W = 11;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int BAR_WIDTH    = 80;

   typedef logic [11:0] rgb_t;

   localparam rgb_t WHITE   = 12'hFFF;
   localparam rgb_t YELLOW  = 12'hFF0;
   localparam rgb_t CYAN    = 12'h0FF;
   localparam rgb_t GREEN   = 12'h0F0;
   localparam rgb_t MAGENTA = 12'hF0F;
   localparam rgb_t RED     = 12'hF00;
   localparam rgb_t BLUE    = 12'h00F;
   localparam rgb_t BLACK   = 12'h000;

   function automatic rgb_t bar_colour(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = WHITE;
         3'd1:    c = YELLOW;
         3'd2:    c = CYAN;
         3'd3:    c = GREEN;
         3'd4:    c = MAGENTA;
         3'd5:    c = RED;
         3'd6:    c = BLUE;
         default: c = BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that delays the raw {active, hs, vs} flags so they
// line up with pixel data returning from the overlay renderers.
module vga_sync_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster counter plus delay-aligned sync/blank/pixel output stage.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scan_driver
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit SYNC_POL  = 1'b0,
   parameter int PIX_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   input  logic [11:0]        VGA_data,
   output logic [COORD_W-1:0] VGA_xpos,
   output logic [COORD_W-1:0] VGA_ypos,
   output logic               VGA_hs,
   output logic               VGA_vs,
   output logic [11:0]        VGA_rgb,
   output logic               frame_start
);

   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(LINE_LEN - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(FRAME_LINES - 1);
   localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic               raw_active, raw_hs, raw_vs;
   logic               dly_active, dly_hs, dly_vs;
   rgb_t               pix;
   logic               hs_reg, vs_reg;
   rgb_t               rgb_reg;
   logic               frame_start_reg;

   // Raster counters; frame_start marks the step that lands on (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xpos            <= '0;
         ypos            <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= 1'b0;
         if (pix_en) begin
            if (xpos == H_LAST) begin
               xpos <= '0;
               if (ypos == V_LAST) begin
                  ypos            <= '0;
                  frame_start_reg <= 1'b1;
               end else begin
                  ypos <= ypos + COORD_W'(1);
               end
            end else begin
               xpos <= xpos + COORD_W'(1);
            end
         end
      end
   end

   always_comb begin
      raw_active = (xpos < H_ACT_C) && (ypos < V_ACT_C);
      raw_hs     = (xpos >= HS_START) && (xpos < HS_END);
      raw_vs     = (ypos >= VS_START) && (ypos < VS_END);
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int PIPE_W = 6;
   logic [2:0]        bar_raw, bar_dly;
   logic [PIPE_W-1:0] pipe_in, pipe_out;
   // The bar index rides the delay line so it stays aligned with the blanking flags.
   assign bar_raw = 3'(xpos / COORD_W'(BAR_WIDTH));
   assign pipe_in = {bar_raw, raw_active, raw_hs, raw_vs};
   assign {bar_dly, dly_active, dly_hs, dly_vs} = pipe_out;
   assign pix = test_mode ? bar_colour(bar_dly) : VGA_data;
`else
   localparam int PIPE_W = 3;
   logic [PIPE_W-1:0] pipe_in, pipe_out;
   assign pipe_in = {raw_active, raw_hs, raw_vs};
   assign {dly_active, dly_hs, dly_vs} = pipe_out;
   assign pix = VGA_data;
`endif

   vga_sync_delay #(
      .WIDTH (PIPE_W),
      .DEPTH (PIX_DELAY)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (pix_en),
      .din  (pipe_in),
      .dout (pipe_out)
   );

   // Output stage adds one more step, so a coordinate's pixel lands PIX_DELAY+1 steps later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_reg  <= ~SYNC_POL;
         vs_reg  <= ~SYNC_POL;
         rgb_reg <= BLACK;
      end else if (pix_en) begin
         hs_reg  <= dly_hs ? SYNC_POL : ~SYNC_POL;
         vs_reg  <= dly_vs ? SYNC_POL : ~SYNC_POL;
         rgb_reg <= dly_active ? pix : BLACK;
      end
   end

   assign VGA_xpos    = xpos;
   assign VGA_ypos    = ypos;
   assign VGA_hs      = hs_reg;
   assign VGA_vs      = vs_reg;
   assign VGA_rgb     = rgb_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver on a reduced raster: the driver pushes the
// expected outputs of every clk, a negedge monitor pops and compares them.
module tb_vga_scan_driver;

   localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VA = 6, VF = 1, VSY = 2, VB = 1;
   localparam int VT = VA + VF + VSY + VB;
   localparam int FT = HT * VT;
   localparam int D  = 2;
   localparam bit POL = 1'b0;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic        mode;
   logic [11:0] VGA_data;
   logic [10:0] VGA_xpos, VGA_ypos;
   logic        VGA_hs, VGA_vs, frame_start;
   logic [11:0] VGA_rgb;
   logic [11:0] d1, d2;

   always #5 clk = ~clk;

   // Overlay model with two clk of latency.
   always @(posedge clk) begin
      d1 <= {VGA_xpos[3:0], VGA_ypos[3:0], 4'h5};
      d2 <= d1;
   end
   always_comb VGA_data = mode ? d2 : 12'hFFF;

   vga_scan_driver #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
      .SYNC_POL (POL), .PIX_DELAY (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (1'b0),
`endif
      .VGA_data    (VGA_data),
      .VGA_xpos    (VGA_xpos),
      .VGA_ypos    (VGA_ypos),
      .VGA_hs      (VGA_hs),
      .VGA_vs      (VGA_vs),
      .VGA_rgb     (VGA_rgb),
      .frame_start (frame_start)
   );

   typedef struct {
      int          s;
      int          x;
      int          y;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
   } exp_t;

   exp_t sb[$];
   int   step = 0;
   bit   adv;
   int   checks = 0;
   int   errors = 0;

   // Expected outputs after s pixel steps since reset release.
   function automatic exp_t predict(input int s, input bit a, input logic r, input logic m);
      exp_t e;
      int   c, cx, cy;
      e.s   = s;
      e.x   = s % HT;
      e.y   = (s / HT) % VT;
      e.fs  = a && (s > 0) && ((s % FT) == 0);
      e.hs  = ~POL;
      e.vs  = ~POL;
      e.rgb = 12'h000;
      if (!r && s >= D + 1) begin
         c  = s - D - 1;
         cx = c % HT;
         cy = (c / HT) % VT;
         if (cx >= HA + HF && cx < HA + HF + HSY) e.hs = POL;
         if (cy >= VA + VF && cy < VA + VF + VSY) e.vs = POL;
         if (cx < HA && cy < VA)
            e.rgb = m ? {4'(cx), 4'(cy), 4'h5} : 12'hFFF;
      end
      return e;
   endfunction

   task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s step=%0d got=%0h want=%0h", name, s, act, want);
      end
   endtask

   task automatic cyc(input logic n_en, input logic n_rst, input logic n_mode);
      @(posedge clk);
      adv = (pix_en === 1'b1) && (rst === 1'b0);
      if (adv) step++;
      #1;
      pix_en = n_en;
      rst    = n_rst;
      mode   = n_mode;
      if (rst) begin
         step = 0;
         adv  = 1'b0;
      end
      sb.push_back(predict(step, adv, rst, mode));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("xpos",        e.s, 32'(VGA_xpos),    32'(e.x));
            chk("ypos",        e.s, 32'(VGA_ypos),    32'(e.y));
            chk("hs",          e.s, 32'(VGA_hs),      32'(e.hs));
            chk("vs",          e.s, 32'(VGA_vs),      32'(e.vs));
            chk("rgb",         e.s, 32'(VGA_rgb),     32'(e.rgb));
            chk("frame_start", e.s, 32'(frame_start), 32'(e.fs));
         end
      end
   end

   initial begin : stimulus
      rst    = 1'b1;
      pix_en = 1'b0;
      mode   = 1'b0;
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      $display("txn reset: initial reset held 3 clk");

      for (int i = 0; i < 600; i++) cyc(1'b1, 1'b0, 1'b0);
      $display("txn full-rate: 600 steps, VGA_data=FFF");

      repeat (2) cyc(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 640; i++) cyc(1'b1, 1'b0, 1'b1);
      $display("txn overlay: 640 steps, coordinate overlay with 2-clk latency");

      repeat (2) cyc(1'b1, 1'b1, 1'b0);
      $display("txn reset: mid-frame reset pulse");
      for (int i = 0; i < 1100; i++) cyc((i % 4) == 0, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      $display("txn sparse: pix_en 1 in 4 for 1100 clk");

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d want=0 pending entries", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
